detector_sequencer: RTL and testbench

DETECTOR_SEQUENCER -- requirements
Module: detector_sequencer

---
 rtl/detector_sequencer.sv | 139 +++++++++++++
 tb/tb_detector_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/detector_sequencer.sv
// Test sequencer for a serial sequence detector: resets it, streams a pattern MSB first, counts detections.
// Optional DETSEQ_LOOP_EN adds a `loop` input that repeats passes without re-clearing the detector.
module detector_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [23:0] pattern,
  input  logic [4:0]  len,
  input  logic        det_z,
`ifdef DETSEQ_LOOP_EN
  input  logic        loop,
`endif
  output logic        det_rst,
  output logic        det_ena,
  output logic        det_sig,
  output logic        busy,
  output logic        done,
  output logic [7:0]  hit_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state;
  logic [23:0] pat_r;
  logic [4:0]  len_r;
  logic [4:0]  idx;
  logic [4:0]  eff_len;
`ifdef DETSEQ_LOOP_EN
  logic        loop_r;
`endif

  always_comb begin
    eff_len = len;
    if (len == 5'd0 || len > 5'd24) eff_len = 5'd24;
  end

  // Outputs are computed for the state being entered, so they change together with it.
  // NOTE: all state and outputs use non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pat_r     <= '0;
      len_r     <= '0;
      idx       <= '0;
      hit_count <= '0;
      det_rst   <= 1'b0;
      det_ena   <= 1'b0;
      det_sig   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef DETSEQ_LOOP_EN
      loop_r    <= 1'b0;
`endif
    end else begin
      if ((state == STREAM || state == DRAIN) && det_z && hit_count != 8'hFF)
        hit_count <= hit_count + 8'd1;

      if (abort && (state == CLEAR || state == STREAM || state == DRAIN)) begin
        state   <= IDLE;
        det_rst <= 1'b0;
        det_ena <= 1'b0;
        det_sig <= 1'b0;
        busy    <= 1'b0;
        done    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              pat_r     <= pattern;
              len_r     <= eff_len;
              hit_count <= 8'd0;
              det_rst   <= 1'b1;
              busy      <= 1'b1;
              state     <= CLEAR;
            end
          end
          CLEAR: begin
            det_rst <= 1'b0;
            det_ena <= 1'b1;
            det_sig <= pat_r[23];
            idx     <= 5'd0;
            state   <= STREAM;
          end
          STREAM: begin
            if (idx == len_r - 5'd1) begin
              det_ena <= 1'b0;
              det_sig <= 1'b0;
              state   <= DRAIN;
            end else begin
              // idx <= 22 here, so the next bit index 23-(idx+1) stays in range.
              idx     <= idx + 5'd1;
              det_sig <= pat_r[5'd22 - idx];
            end
          end
          DRAIN: begin
            done  <= 1'b1;
            state <= DONE;
`ifdef DETSEQ_LOOP_EN
            loop_r <= loop;
`endif
          end
          DONE: begin
            done <= 1'b0;
`ifdef DETSEQ_LOOP_EN
            if (loop_r) begin
              det_ena <= 1'b1;
              det_sig <= pat_r[23];
              idx     <= 5'd0;
              state   <= STREAM;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
`else
            busy  <= 1'b0;
            state <= IDLE;
`endif
          end
          default: begin
            state   <= IDLE;
            det_rst <= 1'b0;
            det_ena <= 1'b0;
            det_sig <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_detector_sequencer.sv
// Directed bench for detector_sequencer: single pass, counting, length clamp, abort, reset, loop saturation.
module tb_detector_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [23:0] pattern;
  logic [4:0]  len;
  logic        det_z;
`ifdef DETSEQ_LOOP_EN
  logic        loop;
`endif
  logic        det_rst;
  logic        det_ena;
  logic        det_sig;
  logic        busy;
  logic        done;
  logic [7:0]  hit_count;

  int n_cmp = 0;
  int n_err = 0;

  detector_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .pattern   (pattern),
    .len       (len),
    .det_z     (det_z),
`ifdef DETSEQ_LOOP_EN
    .loop      (loop),
`endif
    .det_rst   (det_rst),
    .det_ena   (det_ena),
    .det_sig   (det_sig),
    .busy      (busy),
    .done      (done),
    .hit_count (hit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launches one run and observes it at negedges, driving det_z from hit_mask by stream index.
  task automatic run_pass(input string tag, input logic [23:0] pat, input logic [4:0] ln,
                          input int exp_l, input logic [23:0] hit_mask, input logic drain_z,
                          input int exp_hits);
    int busy_c = 0;
    int clr_c  = 0;
    int str_c  = 0;
    int drn_c  = 0;
    int done_c = 0;
    int sig_err = 0;
    logic [23:0] sig_v = '0;
    pattern = pat;
    len     = ln;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_after_start"}, busy, 1);
    for (int cyc = 0; cyc < 40 && busy; cyc++) begin
      busy_c++;
      if (det_rst) clr_c++;
      if (done) done_c++;
      if (det_ena) begin
        sig_v = {sig_v[22:0], det_sig};
        det_z = (str_c < 24) ? hit_mask[str_c] : 1'b0;
        str_c++;
      end else begin
        if (det_sig) sig_err++;
        det_z = 1'b0;
        if (!det_rst && !done) begin
          drn_c++;
          det_z = drain_z;
        end
      end
      @(negedge clk);
    end
    det_z = 1'b0;
    check({tag, "_finished"}, busy, 0);
    check({tag, "_busy_cycles"}, busy_c, exp_l + 3);
    check({tag, "_clear_cycles"}, clr_c, 1);
    check({tag, "_stream_cycles"}, str_c, exp_l);
    check({tag, "_drain_cycles"}, drn_c, 1);
    check({tag, "_done_pulses"}, done_c, 1);
    check({tag, "_sig_idle_zero"}, sig_err, 0);
    check({tag, "_sig_bits"}, sig_v, pat >> (24 - exp_l));
    check({tag, "_hits"}, hit_count, exp_hits);
    @(negedge clk);
    check({tag, "_hits_held"}, hit_count, exp_hits);
    check({tag, "_idle_outs"}, {det_rst, det_ena, det_sig, busy, done}, 0);
  endtask

  initial begin
    int bad;
    rst = 1'b0; start = 1'b0; abort = 1'b0; pattern = '0; len = '0; det_z = 1'b0;
`ifdef DETSEQ_LOOP_EN
    loop = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    check("reset_outs", {det_rst, det_ena, det_sig, busy, done, hit_count}, 0);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_idle", busy, 0);

    // Single pass with hits at k=3,7,12 and length clamp cases.
    run_pass("single", 24'h131753, 5'd24, 24, 24'h001088, 1'b0, 3);
    run_pass("len0",   24'h800001, 5'd0,  24, 24'h000000, 1'b1, 1);
    run_pass("len30",  24'h5A5A5A, 5'd30, 24, 24'h800001, 1'b0, 2);
    run_pass("len5",   24'hA5C3F0, 5'd5,  5,  24'h000010, 1'b0, 1);

    // Abort at k=10, with a start pulse at k=4 that must be ignored.
    pattern = 24'hF0F0F0; len = 5'd24; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (!det_ena || det_rst) bad++;
      det_z = (k == 2 || k == 5);
      start = (k == 4);
      @(negedge clk);
    end
    det_z = 1'b0; start = 1'b0;
    check("abort_no_restart", bad, 0);
    check("abort_still_streaming", {det_rst, det_ena}, 2'b01);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_outs", {det_ena, busy, done}, 0);
    check("abort_partial_hits", hit_count, 2);
    @(negedge clk);
    check("abort_no_done", {busy, done}, 0);

    // abort together with start in IDLE: start wins.
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("abort_start_idle", {busy, det_rst}, 2'b11);
    for (int cyc = 0; cyc < 40 && busy; cyc++) @(negedge clk);
    check("abort_start_finish", busy, 0);

    // Asynchronous reset at k=5.
    pattern = 24'hFFFFFF; len = 5'd24; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      det_z = (k == 1);
      @(negedge clk);
    end
    det_z = 1'b0;
    check("rstmid_pre", {det_ena, det_sig, hit_count}, {2'b11, 8'd1});
    #2 rst = 1'b0;
    #1 check("rstmid_async", {det_rst, det_ena, det_sig, busy, done, hit_count}, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rstmid_no_resume", {busy, det_rst, det_ena}, 0);

`ifdef DETSEQ_LOOP_EN
    begin
      int passes = 0;
      int dones  = 0;
      int clears = 0;
      logic prev_ena = 1'b0;
      loop = 1'b1; det_z = 1'b1; pattern = 24'h123456; len = 5'd24; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 500 && busy; cyc++) begin
        if (det_rst) clears++;
        if (done) dones++;
        if (det_ena && !prev_ena) passes++;
        prev_ena = det_ena;
        if (passes >= 12) loop = 1'b0;
        @(negedge clk);
      end
      det_z = 1'b0; loop = 1'b0;
      check("loop_finished", busy, 0);
      check("loop_saturated", hit_count, 255);
      check("loop_passes", passes, 12);
      check("loop_done_per_pass", dones, 12);
      check("loop_single_clear", clears, 1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
